// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
//   Iterative multiply/divide unit in the EX stage. It takes rs/rt from the
//   ID/EX register and computes MULT/MULTU/DIV/DIVU into the architectural
//   HI/LO registers. One iteration runs per cycle: shift-add for multiply and
//   restoring division for divide. Start to result takes 33 cycles (32 CALC
//   cycles plus one FIX cycle).
//
//   Optional feature macro: MULDIV_SIGNED_EN
//     When it is defined, op_i[1] selects signed MULT/DIV.
//     When it is not defined, signed opcodes execute as their unsigned forms.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   start_i        issue strobe; only sampled while idle
//   op_i           00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   operand_a_i    rs (multiplicand / dividend)
//   operand_b_i    rt (multiplier / divisor)
//   mthi_i/mtlo_i  HI/LO move strobes; only honoured while idle without start_i
//   wr_data_i      MTHI/MTLO data
//   busy_o         operation in progress (pipeline stall)
//   done_o         one-cycle pulse when HI/LO are written by an operation
//   div_by_zero_o  last divide had rt == 0; valid with done_o
//   hi_o/lo_o      HI/LO registers
module ex_muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] operand_a_i,
  input  logic [DATA_WIDTH-1:0] operand_b_i,
  input  logic                  mthi_i,
  input  logic                  mtlo_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  div_by_zero_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;

  // Operation context captured at start
  logic                 is_div;
  logic                 div_zero;
  logic                 neg_res;   // negate product / quotient
  logic                 neg_rem;   // remainder follows the dividend's sign
  logic [W-1:0]         a_orig;
  logic [W-1:0]         opnd;      // multiplicand or divisor magnitude
  logic [2*W-1:0]       acc;       // product accumulator; low half holds the quotient when dividing
  logic [W-1:0]         rem;

  // Start-time operand decode
  logic signed [W-1:0]  a_s;
  logic signed [W-1:0]  b_s;
  logic                 sign_a;
  logic                 sign_b;
  logic [W-1:0]         mag_a;
  logic [W-1:0]         mag_b;

  // Per-iteration datapath
  logic [W:0]           mul_sum;
  logic [W:0]           div_shift;
  logic [W-1:0]         div_sub;
  logic                 div_ok;

  // FIX-cycle results
  logic [2*W-1:0]       prod_fix;
  logic [W-1:0]         fix_hi;
  logic [W-1:0]         fix_lo;

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  assign a_s = operand_a_i;
  assign b_s = operand_b_i;

`ifdef MULDIV_SIGNED_EN
  assign sign_a = op_i[1] & (a_s < 0);
  assign sign_b = op_i[1] & (b_s < 0);
`else
  logic unused_op_sign;
  assign unused_op_sign = op_i[1] ^ a_s[W-1] ^ b_s[W-1];
  assign sign_a = 1'b0;
  assign sign_b = 1'b0;
`endif

  assign mag_a = neg_w(operand_a_i, sign_a);
  assign mag_b = neg_w(operand_b_i, sign_b);

  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {rem, acc[W-1]};
    div_ok    = (div_shift >= {1'b0, opnd});
    div_sub   = div_shift[W-1:0] - opnd;
  end

  always_comb begin
    prod_fix = neg_2w(acc, neg_res);
    fix_hi   = prod_fix[2*W-1:W];
    fix_lo   = prod_fix[W-1:0];
    if (is_div) begin
      if (div_zero) begin
        fix_hi = a_orig;
        fix_lo = '1;
      end else begin
        fix_hi = neg_w(rem, neg_rem);
        fix_lo = neg_w(acc[W-1:0], neg_res);
      end
    end
  end

  // Datapath: operand capture at start, one iteration per CALC cycle
  always_ff @(posedge clk) begin
    if (state == IDLE && start_i) begin
      is_div   <= op_i[0];
      div_zero <= op_i[0] && (operand_b_i == '0);
      neg_res  <= sign_a ^ sign_b;
      neg_rem  <= sign_a;
      a_orig   <= operand_a_i;
      rem      <= '0;
      if (op_i[0]) begin
        opnd <= mag_b;
        acc  <= {{W{1'b0}}, mag_a};
      end else begin
        opnd <= mag_a;
        acc  <= {{W{1'b0}}, mag_b};
      end
    end else if (state == CALC) begin
      if (is_div) begin
        rem          <= div_ok ? div_sub : div_shift[W-1:0];
        acc[W-1:0]   <= {acc[W-2:0], div_ok};
      end else begin
        acc <= {mul_sum, acc[W-1:1]};
      end
    end
  end

  // Control: FSM, architectural HI/LO and status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      div_by_zero_o <= 1'b0;
      hi_o          <= '0;
      lo_o          <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state         <= CALC;
            cnt           <= '0;
            busy_o        <= 1'b1;
            div_by_zero_o <= 1'b0;
          end else begin
            if (mthi_i) hi_o <= wr_data_i;
            if (mtlo_i) lo_o <= wr_data_i;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_WIDTH'(W - 1)) state <= FIX;
        end
        FIX: begin
          state         <= IDLE;
          busy_o        <= 1'b0;
          done_o        <= 1'b1;
          div_by_zero_o <= is_div & div_zero;
          hi_o          <= fix_hi;
          lo_o          <= fix_lo;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
